ram_arbiter: RTL and testbench

Two-port access controller for the single-port 16-bit word RAM. Arbitrates between two requesters (m0: instruction fetch, m1: data/load-store) with a req/ack handshake and sequences every RAM access. When compiled with read-modify-write support, it converts byte writes into a read-merge-write pair so the RAM only ever receives full-word writes. Sits between the CPU bus ports and the RAM's address/data/be/we pins.

---
 rtl/ram_pkg.sv | 13 +
 rtl/rr_arb2.sv | 24 ++
 rtl/ram_arbiter.sv | 133 +++++++++++++
 tb/tb_ram_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared FSM encoding, byte-enable and master-index constants for ram_arbiter
package ram_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, MERGE = 2'd2, DONE = 2'd3} state_e;
   localparam logic [1:0] BE_NONE = 2'b00;
   localparam logic [1:0] BE_LO   = 2'b01;
   localparam logic [1:0] BE_HI   = 2'b10;
   localparam logic [1:0] BE_WORD = 2'b11;
   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;
   function automatic logic is_byte(input logic [1:0] be);
      return be == BE_LO || be == BE_HI;
   endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way picker, round-robin on ties unless fixed priority selects m0
// Ports: req0_i/req1_i requests, mask_i drops a request, fixed_prio_i forces m0 on ties,
//        ptr_i last-granted master, gnt_o one-hot grant, ptr_o pointer after this grant.
module rr_arb2
   import ram_pkg::*;
(
   input  logic       req0_i,
   input  logic       req1_i,
   input  logic [1:0] mask_i,
   input  logic       fixed_prio_i,
   input  logic       ptr_i,
   output logic [1:0] gnt_o,
   output logic       ptr_o
);
   logic r0, r1, pick1;
   always_comb begin
      r0    = req0_i & ~mask_i[0];
      r1    = req1_i & ~mask_i[1];
      // m1 wins alone, or on a tie when m0 was granted last
      pick1 = r1 & (~r0 | (~fixed_prio_i & (ptr_i == M0)));
      gnt_o = {pick1, r0 & ~pick1};
      ptr_o = (r0 | r1) ? pick1 : ptr_i;
   end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master req/ack access controller for a single-port 16-bit word RAM
// Ports: m0_*/m1_* requester buses (req, addr, we, be, wdata in; ack, rdata out),
//        ram_addr/ram_wdata/ram_be/ram_we registered RAM pins, ram_rdata RAM data (1-cycle latency).
// Parameter FIXED_PRIO: 0 round-robin, 1 m0 always wins ties.
// Macro RAM_ARB_RMW_EN: byte writes become a read-merge-write so the RAM only sees word writes.
module ram_arbiter
   import ram_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        m0_req,
   input  logic        m1_req,
   input  logic [15:0] m0_addr,
   input  logic [15:0] m1_addr,
   input  logic        m0_we,
   input  logic        m1_we,
   input  logic [1:0]  m0_be,
   input  logic [1:0]  m1_be,
   input  logic [15:0] m0_wdata,
   input  logic [15:0] m1_wdata,
   output logic        m0_ack,
   output logic        m1_ack,
   output logic [15:0] m0_rdata,
   output logic [15:0] m1_rdata,
   output logic [15:0] ram_addr,
   output logic [15:0] ram_wdata,
   output logic [1:0]  ram_be,
   output logic        ram_we,
   input  logic [15:0] ram_rdata
);
   state_e      state_q, state_d;
   logic [15:0] ram_addr_q, ram_addr_d, ram_wdata_q, ram_wdata_d;
   logic [1:0]  ram_be_q, ram_be_d, gnt, mask, s_be;
   logic        ram_we_q, ram_we_d, win_q, win_d, ptr_q, ptr_d, ptr_nxt, s_we;
   logic [15:0] s_addr, s_wdata;
   // the master just served cannot be re-granted straight from DONE
   assign mask = (state_q == DONE) ? ((win_q == M1) ? 2'b10 : 2'b01) : 2'b00;
   rr_arb2 u_arb (
      .req0_i      (m0_req),
      .req1_i      (m1_req),
      .mask_i      (mask),
      .fixed_prio_i(FIXED_PRIO),
      .ptr_i       (ptr_q),
      .gnt_o       (gnt),
      .ptr_o       (ptr_nxt)
   );
   assign s_we    = gnt[1] ? m1_we    : m0_we;
   assign s_be    = gnt[1] ? m1_be    : m0_be;
   assign s_addr  = gnt[1] ? m1_addr  : m0_addr;
   assign s_wdata = gnt[1] ? m1_wdata : m0_wdata;
`ifdef RAM_ARB_RMW_EN
   logic        w_we;
   logic [1:0]  w_be;
   logic [15:0] w_wdata;
   // requester fields stay stable until ack, so the winner's bus is read directly
   assign w_we    = (win_q == M1) ? m1_we    : m0_we;
   assign w_be    = (win_q == M1) ? m1_be    : m0_be;
   assign w_wdata = (win_q == M1) ? m1_wdata : m0_wdata;
`endif
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_be_q    <= BE_WORD;
         ram_we_q    <= 1'b0;
         win_q       <= M0;
         ptr_q       <= M1;
      end else begin
         state_q     <= state_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_be_q    <= ram_be_d;
         ram_we_q    <= ram_we_d;
         win_q       <= win_d;
         ptr_q       <= ptr_d;
      end
   end
   always_comb begin
      state_d     = state_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_be_d    = ram_be_q;
      ram_we_d    = 1'b0;
      win_d       = win_q;
      ptr_d       = ptr_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = (|gnt) ? ACCESS : IDLE;
            if (|gnt) begin
               win_d       = gnt[1];
               ptr_d       = ptr_nxt;
               ram_addr_d  = s_addr;
               ram_wdata_d = s_wdata;
               ram_be_d    = s_be;
               ram_we_d    = s_we && (s_be != BE_NONE);
`ifdef RAM_ARB_RMW_EN
               // a byte write first reads the whole word
               if (s_we && is_byte(s_be)) begin
                  ram_be_d = BE_WORD;
                  ram_we_d = 1'b0;
               end
`endif
            end
         end
`ifdef RAM_ARB_RMW_EN
         ACCESS: state_d = (w_we && is_byte(w_be)) ? MERGE : DONE;
         MERGE: begin
            state_d     = DONE;
            ram_we_d    = 1'b1;
            ram_be_d    = BE_WORD;
            ram_wdata_d = (w_be == BE_LO) ? {ram_rdata[15:8], w_wdata[7:0]}
                                          : {w_wdata[15:8], ram_rdata[7:0]};
         end
`else
         ACCESS: state_d = DONE;
`endif
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      m0_ack   = (state_q == DONE) && (win_q == M0);
      m1_ack   = (state_q == DONE) && (win_q == M1);
      m0_rdata = m0_ack ? ram_rdata : '0;
      m1_rdata = m1_ack ? ram_rdata : '0;
   end
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ram_be    = ram_be_q;
   assign ram_we    = ram_we_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random transactions checked against a transaction-level memory/arbitration model
module tb_ram_arbiter;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mreq [0:1];
   logic        mwe  [0:1];
   logic [1:0]  mbe  [0:1];
   logic [15:0] maddr[0:1];
   logic [15:0] mwd  [0:1];
   logic [1:0]  ack;
   logic [15:0] rd   [0:1];
   logic [15:0] ram_addr, ram_wdata, ram_rdata;
   logic [1:0]  ram_be;
   logic        ram_we;
   logic [15:0] mem    [0:65535];
   logic [15:0] ref_mem[0:65535];
   int n_chk = 0, n_fail = 0, last_g = 1;

   always #5 clk = ~clk;

   ram_arbiter #(.FIXED_PRIO(1'b0)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_req(mreq[0]), .m1_req(mreq[1]), .m0_addr(maddr[0]), .m1_addr(maddr[1]),
      .m0_we(mwe[0]), .m1_we(mwe[1]), .m0_be(mbe[0]), .m1_be(mbe[1]),
      .m0_wdata(mwd[0]), .m1_wdata(mwd[1]), .m0_ack(ack[0]), .m1_ack(ack[1]),
      .m0_rdata(rd[0]), .m1_rdata(rd[1]), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_be(ram_be), .ram_we(ram_we), .ram_rdata(ram_rdata)
   );

   // single-port RAM: registered read of the old word, byte-enabled write
   always @(posedge clk) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) begin
         if (ram_be[0]) mem[ram_addr][7:0] = ram_wdata[7:0];
         if (ram_be[1]) mem[ram_addr][15:8] = ram_wdata[15:8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic rmw_byte(input logic we, input logic [1:0] be);
`ifdef RAM_ARB_RMW_EN
      return we && (be == 2'b01 || be == 2'b10);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int lat(input logic we, input logic [1:0] be);
      return rmw_byte(we, be) ? 3 : 2;
   endfunction

   function automatic int n_writes(input logic we, input logic [1:0] be);
      return (we && be != 2'b00) ? 1 : 0;
   endfunction

   task automatic ref_write(input logic [15:0] a, input logic [1:0] be, input logic [15:0] wd);
      if (be[0]) ref_mem[a] = (ref_mem[a] & 16'hFF00) | (wd & 16'h00FF);
      if (be[1]) ref_mem[a] = (ref_mem[a] & 16'h00FF) | (wd & 16'hFF00);
   endtask

   task automatic xact(input int m, input logic [15:0] a, input logic we, input logic [1:0] be,
                       input logic [15:0] wd);
      int got, wcnt, wat, o;
      logic [1:0] wbe;
      logic other;
      logic [15:0] rdv, exp_rd;
      o = 1 - m;
      exp_rd = ref_mem[a];
      @(negedge clk);
      maddr[m] = a; mwe[m] = we; mbe[m] = be; mwd[m] = wd; mreq[m] = 1'b1;
      got = 0; wcnt = 0; wat = 0; wbe = 2'b00; other = 1'b0; rdv = '0;
      for (int n = 1; n <= 8 && got == 0; n++) begin
         @(negedge clk);
         if (ram_we) begin wcnt++; wat = n; wbe = ram_be; end
         if (ack[o]) other = 1'b1;
         if (ack[m]) begin got = n; rdv = rd[m]; mreq[m] = 1'b0; end
      end
      mreq[m] = 1'b0;
      chk("ack_latency", got, lat(we, be));
      chk("other_ack", {31'd0, other}, 32'd0);
      if (!we) chk("rdata", rdv, exp_rd);
      else begin
         chk("we_pulses", wcnt, n_writes(we, be));
         if (be != 2'b00) begin
            chk("we_be", wbe, rmw_byte(we, be) ? 2'b11 : be);
            if (!rmw_byte(we, be)) chk("we_cycle", wat, 1);
            ref_write(a, be, wd);
         end
      end
      last_g = m;
   endtask

   task automatic pair(input logic [15:0] a0, input logic we0, input logic [1:0] be0, input logic [15:0] wd0,
                       input logic [15:0] a1, input logic we1, input logic [1:0] be1, input logic [15:0] wd1);
      int w, l, got[2], wcnt, lt[2];
      logic [15:0] a[2], wd[2], exp_rd[2], rdv[2];
      logic we[2];
      logic [1:0] be[2];
      a = '{a0, a1}; we = '{we0, we1}; be = '{be0, be1}; wd = '{wd0, wd1};
      w = (last_g == 1) ? 0 : 1;
      l = 1 - w;
      exp_rd[w] = ref_mem[a[w]];
      if (we[w]) ref_write(a[w], be[w], wd[w]);
      exp_rd[l] = ref_mem[a[l]];
      if (we[l]) ref_write(a[l], be[l], wd[l]);
      lt[w] = lat(we[w], be[w]);
      lt[l] = lt[w] + lat(we[l], be[l]);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         maddr[m] = a[m]; mwe[m] = we[m]; mbe[m] = be[m]; mwd[m] = wd[m]; mreq[m] = 1'b1;
         got[m] = 0; rdv[m] = '0;
      end
      wcnt = 0;
      for (int n = 1; n <= 12 && (got[0] == 0 || got[1] == 0); n++) begin
         @(negedge clk);
         if (ram_we) wcnt++;
         for (int m = 0; m < 2; m++)
            if (ack[m] && got[m] == 0) begin got[m] = n; rdv[m] = rd[m]; mreq[m] = 1'b0; end
      end
      mreq[0] = 1'b0; mreq[1] = 1'b0;
      chk("tie_winner_ack", got[w], lt[w]);
      chk("tie_loser_ack", got[l], lt[l]);
      for (int m = 0; m < 2; m++) if (!we[m]) chk("tie_rdata", rdv[m], exp_rd[m]);
      chk("tie_we_pulses", wcnt, n_writes(we[0], be[0]) + n_writes(we[1], be[1]));
      last_g = l;
   endtask

   initial begin
      for (int m = 0; m < 2; m++) begin
         mreq[m] = 1'b0; mwe[m] = 1'b0; mbe[m] = 2'b11; maddr[m] = '0; mwd[m] = '0;
      end
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 16'(i * 40503) ^ 16'h5A5A;
         ref_mem[i] = mem[i];
      end
      mem[16'h0080] = 16'hBEEF; ref_mem[16'h0080] = 16'hBEEF;
      mem[16'h0010] = 16'h1234; ref_mem[16'h0010] = 16'h1234;
      repeat (2) @(negedge clk);
      chk("rst_ram_addr", ram_addr, 16'h0000);
      chk("rst_ram_wdata", ram_wdata, 16'h0000);
      chk("rst_ram_be", ram_be, 2'b11);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_acks", ack, 2'b00);
      reset_n = 1'b1;
      // first tie after reset goes to m0, then m1 from DONE, next tie m0 again
      pair(16'h0080, 1'b0, 2'b11, 16'h0, 16'h0010, 1'b0, 2'b11, 16'h0);
      pair(16'h0081, 1'b0, 2'b11, 16'h0, 16'h0082, 1'b0, 2'b11, 16'h0);
      xact(0, 16'h0080, 1'b0, 2'b11, 16'h0000);
      chk("beef_read", ref_mem[16'h0080], 16'hBEEF);
      xact(1, 16'h0010, 1'b1, 2'b01, 16'h00AB);
      xact(1, 16'h0010, 1'b0, 2'b11, 16'h0000);
      chk("merge_lo", mem[16'h0010], 16'h12AB);
      xact(1, 16'h0010, 1'b1, 2'b10, 16'hCD00);
      xact(0, 16'h0010, 1'b0, 2'b11, 16'h0000);
      chk("merge_hi", mem[16'h0010], 16'hCDAB);
      xact(0, 16'h0011, 1'b1, 2'b00, 16'hFFFF);
      xact(0, 16'h0011, 1'b0, 2'b11, 16'h0000);
      xact(1, 16'h0012, 1'b1, 2'b11, 16'h7E57);
      xact(0, 16'h0012, 1'b0, 2'b11, 16'h0000);
      // reset while a word write is in ACCESS
      @(negedge clk);
      maddr[0] = 16'h0020; mwe[0] = 1'b1; mbe[0] = 2'b11; mwd[0] = 16'h5555; mreq[0] = 1'b1;
      @(negedge clk);
      chk("pre_rst_we", ram_we, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("arst_ram_we", ram_we, 1'b0);
      chk("arst_ram_be", ram_be, 2'b11);
      chk("arst_ram_addr", ram_addr, 16'h0000);
      chk("arst_ram_wdata", ram_wdata, 16'h0000);
      chk("arst_acks", ack, 2'b00);
      @(negedge clk);
      chk("arst_hold_acks", ack, 2'b00);
      mreq[0] = 1'b0;
      reset_n = 1'b1;
      last_g = 1;
      pair(16'h0020, 1'b0, 2'b11, 16'h0, 16'h0021, 1'b0, 2'b11, 16'h0);
      chk("abort_no_write", mem[16'h0020], ref_mem[16'h0020]);
      for (int it = 0; it < 40; it++) begin
         logic [15:0] a0, a1, d0, d1;
         logic w0, w1;
         logic [1:0] b0, b1;
         a0 = 16'h0100 + 16'($urandom_range(0, 7));
         a1 = 16'h0100 + 16'($urandom_range(0, 7));
         d0 = 16'($urandom); d1 = 16'($urandom);
         w0 = 1'($urandom); w1 = 1'($urandom);
         b0 = 2'($urandom); b1 = 2'($urandom);
         if ($urandom_range(0, 1) == 0) xact(int'($urandom_range(0, 1)), a0, w0, b0, d0);
         else pair(a0, w0, b0, d0, a1, w1, b1, d1);
      end
      for (int i = 0; i < 8; i++) xact(i % 2, 16'h0100 + 16'(i), 1'b0, 2'b11, 16'h0000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
